// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache backing memory.
// Word width, FSM encoding and address-to-block slicing.
package cache_mem_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic [31:0] blk_addr(
    input logic [31:0] addr,
    input int unsigned word_off_w
  );
    return addr >> (BYTE_OFF_W + word_off_w);
  endfunction

endpackage

// File: rtl/cache_backing_mem.sv
// Block-granular memory responder behind the L1 refill port.
// One request in flight; fixed latency, then a beat burst or write ack.
module cache_backing_mem
  import cache_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = 1,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [31:0]                   req_addr,
  input  logic [WORD_W*BLOCK_WORDS-1:0] req_wdata,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [WORD_W-1:0]             resp_rdata,
  output logic                          resp_last,
  output logic                          resp_write
);

  localparam int NBLK   = DEPTH_WORDS / BLOCK_WORDS;
  localparam int IDX_W  = $clog2(NBLK);
  localparam int WOFF_W = $clog2(BLOCK_WORDS);
  localparam int BEAT_W = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int LINE_W = WORD_W * BLOCK_WORDS;

  logic [LINE_W-1:0] mem_q [NBLK];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0]  blk_q, blk_d;
  logic              wr_q, wr_d;

  logic [31:0]       idx_full;
  logic [IDX_W-1:0]  idx;
  logic              unused_idx;
  logic              req_fire;
  logic              resp_fire;
  logic              beat_last;
  logic [LINE_W-1:0] rd_line;
  logic [WORD_W-1:0] rd_word;

  // High address bits beyond the array simply alias
  assign idx_full   = blk_addr(req_addr, WOFF_W);
  assign idx        = idx_full[IDX_W-1:0];
  assign unused_idx = ^idx_full[31:IDX_W];

  assign req_fire  = req_valid & req_ready;
  assign resp_fire = resp_valid & resp_ready;
  assign beat_last = (beat_q == BEAT_W'(BLOCK_WORDS - 1));
  assign rd_line   = mem_q[blk_q];
  assign rd_word   = rd_line[WORD_W*int'(beat_q) +: WORD_W];

  always_ff @(posedge CLK) begin
    if (req_fire && req_write) begin
      mem_q[idx] <= req_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      blk_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    wr_d    = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(LATENCY - 1);
          blk_d   = idx;
          wr_d    = req_write;
          beat_d  = '0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_fire) begin
          if (wr_q || beat_last) begin
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced quiet while RESET is high
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_write = 1'b0;
    resp_last  = 1'b0;
    resp_rdata = '0;
    if (!RESET) begin
      req_ready = (state_q == ST_IDLE);
      if (state_q == ST_RESP) begin
        resp_valid = 1'b1;
        resp_write = wr_q;
        resp_last  = wr_q | beat_last;
        if (!wr_q) begin
          resp_rdata = rd_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_backing_mem.sv
// Bench for cache_backing_mem: two configurations against a word-array model.
// Directed scenarios followed by randomized aliased reads and writes.
module tb_cache_backing_mem;

  localparam int BW0 = 4, DEP0 = 4096, LAT0 = 4;
  localparam int BW1 = 2, DEP1 = 256,  LAT1 = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid  [2];
  logic         req_ready  [2];
  logic         req_write  [2];
  logic [31:0]  req_addr   [2];
  logic [127:0] req_wdata  [2];
  logic         resp_valid [2];
  logic         resp_ready [2];
  logic [31:0]  resp_rdata [2];
  logic         resp_last  [2];
  logic         resp_write [2];

  logic [31:0]  mdl [2][4096];
  int           n_pass = 0;
  int           n_fail = 0;
  int           n_total = 0;

  always #5 clk = ~clk;

  cache_backing_mem #(
    .BLOCK_WORDS(BW0), .DEPTH_WORDS(DEP0), .LATENCY(LAT0)
  ) u_dut0 (
    .CLK(clk), .RESET(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_last(resp_last[0]),
    .resp_write(resp_write[0])
  );

  cache_backing_mem #(
    .BLOCK_WORDS(BW1), .DEPTH_WORDS(DEP1), .LATENCY(LAT1)
  ) u_dut1 (
    .CLK(clk), .RESET(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1][63:0]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_last(resp_last[1]),
    .resp_write(resp_write[1])
  );

  function automatic int bw(int d);
    return (d == 0) ? BW0 : BW1;
  endfunction

  function automatic int dep(int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic int lat(int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // First word of the block an address lands in, after wrap-around
  function automatic int base_word(int d, logic [31:0] a);
    int w;
    w = int'((a >> 2) % 32'(dep(d)));
    return w - (w % bw(d));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; mode 0 ready, 1 = 1,0,0 pattern, 2 random
  task automatic txn(int d, bit wr, logic [31:0] addr,
                     logic [127:0] wd, int mode);
    int base, nb, b, guard;
    logic [31:0] exp;
    bit rdy;
    base = base_word(d, addr);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    resp_ready[d] = 1'b1;
    #1 chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    if (wr) begin
      for (int i = 0; i < bw(d); i++) mdl[d][base+i] = wd[32*i +: 32];
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    for (int k = 0; k < lat(d); k++) begin
      #1;
      chk("wait_valid", 32'(resp_valid[d]), 32'd0);
      chk("wait_ready", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
    end
    nb = wr ? 1 : bw(d);
    b = 0;
    guard = 0;
    while (b < nb && guard < 100) begin
      exp = wr ? 32'd0 : mdl[d][base+b];
      #1;
      chk("beat_valid", 32'(resp_valid[d]), 32'd1);
      chk("beat_rdata", resp_rdata[d], exp);
      chk("beat_last", 32'(resp_last[d]), 32'(b == nb - 1));
      chk("beat_write", 32'(resp_write[d]), 32'(wr));
      rdy = (mode == 0) || (mode == 1 && guard % 3 == 0) ||
            (mode == 2 && $urandom_range(0, 1) == 1);
      resp_ready[d] = rdy;
      @(negedge clk);
      if (rdy) b++;
      guard++;
    end
    chk("beats_done", 32'(b), 32'(nb));
    #1;
    chk("ready_after", 32'(req_ready[d]), 32'd1);
    chk("idle_valid", 32'(resp_valid[d]), 32'd0);
    resp_ready[d] = 1'b1;
  endtask

  initial begin
    logic [127:0] wd;
    logic [31:0]  a;
    int           blk;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b1;
      req_write[d]  = 1'b0;
      req_addr[d]   = '0;
      req_wdata[d]  = '0;
      resp_ready[d] = 1'b1;
    end

    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_valid", 32'(resp_valid[d]), 32'd0);
        chk("rst_ready", 32'(req_ready[d]), 32'd0);
      end
    end
    rst = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rel_ready", 32'(req_ready[d]), 32'd1);
      chk("rel_last", 32'(resp_last[d]), 32'd0);
      chk("rel_write", 32'(resp_write[d]), 32'd0);
      chk("rel_rdata", resp_rdata[d], 32'd0);
    end
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        chk("no_resp", 32'(resp_valid[d]), 32'd0);
    end

    txn(0, 1'b1, 32'h0000_1230,
        {32'd0, 32'd0, 32'd0, 32'd0, 32'h44, 32'h33, 32'h22, 32'h11}, 0);
    txn(0, 1'b0, 32'h0000_123C, '0, 0);
    chk("plan_word0", mdl[0][base_word(0, 32'h123C)], 32'h11);

    txn(0, 1'b1, 32'h0000_2000, {$urandom, $urandom, $urandom, $urandom}, 0);
    txn(0, 1'b0, 32'h0000_2004, '0, 1);

    txn(0, 1'b1, 32'h0000_0040, {$urandom, $urandom, $urandom, $urandom}, 0);
    txn(0, 1'b0, 32'h0000_4040, '0, 0);
    txn(1, 1'b1, 32'h0000_0080, {64'd0, $urandom, $urandom}, 0);
    txn(1, 1'b0, 32'h0000_0480, '0, 0);

    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 32'h0000_2000;
    #1 chk("mr_accept", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    repeat (LAT0) @(negedge clk);
    #1 chk("mr_beat0", resp_rdata[0], mdl[0][base_word(0, 32'h2000)]);
    @(negedge clk);
    #1 chk("mr_beat1", resp_rdata[0], mdl[0][base_word(0, 32'h2000) + 1]);
    @(negedge clk);
    rst = 1'b1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_wdata[0] = {4{32'hDEAD_BEEF}};
    #1;
    chk("mr_rst_valid", 32'(resp_valid[0]), 32'd0);
    chk("mr_rst_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid[0] = 1'b0;
    #1;
    chk("mr_idle", 32'(req_ready[0]), 32'd1);
    repeat (LAT0 + 2) begin
      chk("mr_quiet", 32'(resp_valid[0]), 32'd0);
      @(negedge clk);
    end
    txn(0, 1'b0, 32'h0000_2000, '0, 0);

    txn(1, 1'b0, 32'h0000_0080, '0, 0);
    txn(1, 1'b0, 32'h0000_0480, '0, 0);

    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < 16; b++) begin
        wd = {$urandom, $urandom, $urandom, $urandom};
        txn(d, 1'b1, 32'(b * bw(d) * 4), wd, 0);
      end
      for (int n = 0; n < 30; n++) begin
        blk = $urandom_range(0, 15);
        a = ($urandom & ~32'(dep(d) * 4 - 1)) | 32'(blk * bw(d) * 4) |
            32'($urandom_range(0, bw(d) * 4 - 1));
        wd = {$urandom, $urandom, $urandom, $urandom};
        txn(d, 1'($urandom_range(0, 2) == 0), a, wd,
            $urandom_range(0, 2));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
